// File: rtl/vram_pkg.sv
// Shared types and widths for the VRAM write path: word geometry, writer FSM
// states and the host-write buffer entry layout.
package vram_pkg;

    localparam int VRAM_ADDR_W = 14;
    localparam int VRAM_DATA_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } writer_state_e;

    typedef struct packed {
        logic [VRAM_ADDR_W-1:0] addr;
        logic [VRAM_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset. Pushes while full and
// pops while empty are dropped; there is no push/pop bypass when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vram_writer.sv
// Host-to-VRAM write port: buffers host word writes and drains one per clken edge.
// Optional clear engine sweeping CLEAR_VALUE is built when VRAM_WRITER_CLEAR_EN is defined.
module vram_writer
    import vram_pkg::*;
#(
    parameter int                     FIFO_DEPTH  = 4,
    parameter int                     CLEAR_WORDS = 16384,
    parameter logic [VRAM_DATA_W-1:0] CLEAR_VALUE = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clken,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [VRAM_ADDR_W-1:0] wr_addr,
    input  logic [VRAM_DATA_W-1:0] wr_data,
    input  logic                   clear_req,
    output logic                   busy,
    output logic [VRAM_ADDR_W-1:0] vram_waddr,
    output logic [VRAM_DATA_W-1:0] vram_wdata,
    output logic                   vram_we,
    output writer_state_e          dbg_state
);

    // Handshake: a host word is taken on every rising clk edge where
    // wr_valid && wr_ready; wr_ready depends only on registered state.

    fifo_entry_t             push_entry, head_entry;
    logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;

    writer_state_e           state_q, state_d;
    logic                    we_q, we_d;
    logic [VRAM_ADDR_W-1:0]  waddr_q, waddr_d;
    logic [VRAM_DATA_W-1:0]  wdata_q, wdata_d;

`ifdef VRAM_WRITER_CLEAR_EN
    localparam logic [VRAM_ADDR_W-1:0] CLEAR_LAST = VRAM_ADDR_W'(CLEAR_WORDS - 1);

    logic                    clear_pending_q, clear_pending_d;
    logic [VRAM_ADDR_W-1:0]  cnt_q, cnt_d;

    assign wr_ready = !fifo_full && !clear_pending_q && (state_q == IDLE);
    assign busy     = !fifo_empty || clear_pending_q || (state_q == CLEAR) || we_q;
`else
    logic [VRAM_DATA_W:0]    unused_clear_cfg;

    assign unused_clear_cfg = {clear_req, CLEAR_VALUE ^ VRAM_DATA_W'(CLEAR_WORDS)};
    assign wr_ready         = !fifo_full;
    assign busy             = !fifo_empty || we_q;
`endif

    assign push_entry = '{addr: wr_addr, data: wr_data};
    assign fifo_push  = wr_valid && wr_ready;

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (push_entry),
        .data_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        fifo_pop = 1'b0;
`ifdef VRAM_WRITER_CLEAR_EN
        clear_pending_d = clear_pending_q;
        cnt_d           = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (clken && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    we_d     = 1'b1;
                    waddr_d  = head_entry.addr;
                    wdata_d  = head_entry.data;
                end
`ifdef VRAM_WRITER_CLEAR_EN
                // A queued clear waits until every earlier host word has drained.
                else if (fifo_empty && clear_pending_q) begin
                    state_d         = CLEAR;
                    cnt_d           = '0;
                    clear_pending_d = 1'b0;
                end
                if (clear_req && !clear_pending_q) begin
                    clear_pending_d = 1'b1;
                end
`endif
            end
`ifdef VRAM_WRITER_CLEAR_EN
            CLEAR: begin
                if (clken) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = CLEAR_VALUE;
                    if (cnt_q == CLEAR_LAST) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + VRAM_ADDR_W'(1);
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef VRAM_WRITER_CLEAR_EN
            clear_pending_q <= 1'b0;
            cnt_q           <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef VRAM_WRITER_CLEAR_EN
            clear_pending_q <= clear_pending_d;
            cnt_q           <= cnt_d;
`endif
        end
    end

    assign vram_we    = we_q;
    assign vram_waddr = waddr_q;
    assign vram_wdata = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_vram_writer.sv
// Bench for vram_writer: directed scenarios plus a randomized host-write phase,
// every VRAM write checked in order against an expected-write queue.
module tb_vram_writer;
    import vram_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic                   clk = 1'b0;
    logic                   reset, clken, wr_valid, clear_req;
    logic [VRAM_ADDR_W-1:0] wr_addr;
    logic [VRAM_DATA_W-1:0] wr_data;
    logic                   wr_ready, busy, vram_we;
    logic [VRAM_ADDR_W-1:0] vram_waddr;
    logic [VRAM_DATA_W-1:0] vram_wdata;
    writer_state_e          dbg_state;

    int total = 0;
    int bad   = 0;
    logic [VRAM_ADDR_W+VRAM_DATA_W-1:0] exp_q[$];
    logic [VRAM_ADDR_W+VRAM_DATA_W-1:0] mon_e;

    int   n;
    int   occ;
    logic acc, pop_now;

    vram_writer #(
        .FIFO_DEPTH  (DEPTH),
        .CLEAR_WORDS (CW),
        .CLEAR_VALUE (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clken      (clken),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clear_req  (clear_req),
        .busy       (busy),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_we    (vram_we),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic push_clear_sweep();
        for (int i = 0; i < CW; i++) begin
            exp_q.push_back({VRAM_ADDR_W'(i), 16'h0000});
        end
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            step();
            k++;
        end
        check({tag, " drain"}, exp_q.size(), 0);
    endtask

    // Every strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (vram_we === 1'b1) begin
            check("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("waddr", 32'(vram_waddr), 32'(mon_e[29:16]));
                check("wdata", 32'(vram_wdata), 32'(mon_e[15:0]));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        clken     = 1'b0;
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        repeat (2) step();
        reset = 1'b0;
        check("rst we", vram_we, 0);
        check("rst waddr", vram_waddr, 0);
        check("rst wdata", vram_wdata, 0);
        check("rst ready", wr_ready, 1);
        check("rst busy", busy, 0);

        // Single write, clken alternating.
        wr_valid = 1'b1;
        wr_addr  = 14'h0010;
        wr_data  = 16'hABCD;
        check("t1 ready", wr_ready, 1);
        exp_q.push_back({14'h0010, 16'hABCD});
        step();
        wr_valid = 1'b0;
        check("t1 no early write", vram_we, 0);
        check("t1 busy", busy, 1);
        clken = 1'b1;
        step();
        check("t1 strobe", vram_we, 1);
        clken = 1'b0;
        step();
        check("t1 pulse ends", vram_we, 0);
        check("t1 busy drops", busy, 0);
        clken = 1'b1;
        step();
        check("t1 single pulse", vram_we, 0);

        // Fill the buffer with clken low, then release it.
        clken = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            wr_valid = 1'b1;
            wr_addr  = VRAM_ADDR_W'(i);
            wr_data  = 16'(i * 16'h1111);
            check("t2 ready", wr_ready, 32'(i <= DEPTH));
            if (i <= DEPTH) begin
                exp_q.push_back({VRAM_ADDR_W'(i), 16'(i * 16'h1111)});
                step();
                check("t2 no write clken0", vram_we, 0);
            end
        end
        clken = 1'b1;
        step();
        check("t2 strobe", vram_we, 1);
        check("t2 ready after pop", wr_ready, 1);
        exp_q.push_back({14'd5, 16'h5555});
        step();
        wr_valid = 1'b0;
        drain("t2");
        step();
        check("t2 busy", busy, 0);

`ifdef VRAM_WRITER_CLEAR_EN
        // Plain clear sweep.
        clken     = 1'b1;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        push_clear_sweep();
        for (int k = 0; k < CW + 2; k++) begin
            check("t3 ready", wr_ready, 32'(k == CW + 1));
            check("t3 we", vram_we, 32'(k >= 2));
            if (k < CW + 1) step();
        end
        step();
        check("t3 we end", vram_we, 0);
        check("t3 busy end", busy, 0);
        check("t3 all written", exp_q.size(), 0);

        // Write and clear in one cycle; a second clear mid-sweep is ignored.
        wr_valid  = 1'b1;
        wr_addr   = 14'h3FFF;
        wr_data   = 16'hBEEF;
        clear_req = 1'b1;
        check("t4 ready", wr_ready, 1);
        exp_q.push_back({14'h3FFF, 16'hBEEF});
        push_clear_sweep();
        step();
        wr_valid  = 1'b0;
        clear_req = 1'b0;
        check("t4 ready pending", wr_ready, 0);
        repeat (6) step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("t4 ready mid", wr_ready, 0);
        drain("t4");
        step();
        check("t4 busy end", busy, 0);
        check("t4 we end", vram_we, 0);

        // Reset while the counter sits at 7.
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        push_clear_sweep();
        n = 0;
        while (!(vram_we === 1'b1 && vram_waddr == 14'd6) && n < 40) begin
            step();
            n++;
        end
        check("t5 reached counter 7", 32'(n < 40), 1);
        @(negedge clk);
        #1;
        exp_q.delete();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t5 we", vram_we, 0);
        check("t5 busy", busy, 0);
        check("t5 ready", wr_ready, 1);
        repeat (20) step();
        check("t5 busy later", busy, 0);
`else
        // Clear request has no effect in this build.
        clken     = 1'b1;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("t6 we", vram_we, 0);
            check("t6 busy", busy, 0);
            check("t6 ready", wr_ready, 1);
            step();
        end
`endif

        // Randomized host traffic against an occupancy model.
        reset = 1'b1;
        step();
        reset = 1'b0;
        occ   = 0;
        for (int c = 0; c < 400; c++) begin
            clken    = ($urandom_range(0, 2) == 0);
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_addr  = VRAM_ADDR_W'($urandom_range(0, 16383));
            wr_data  = 16'($urandom_range(0, 65535));
            check("rnd ready", wr_ready, 32'(occ < DEPTH));
            acc     = wr_valid && (occ < DEPTH);
            pop_now = clken && (occ > 0);
            if (acc) exp_q.push_back({wr_addr, wr_data});
            step();
            occ = occ + int'(acc) - int'(pop_now);
            check("rnd we", vram_we, 32'(pop_now));
            check("rnd busy", busy, 32'((occ > 0) || pop_now));
        end
        wr_valid = 1'b0;
        clken    = 1'b1;
        drain("rnd");
        step();
        check("rnd busy end", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_writer.md
# vram_writer

Write-side port for the video RAM: buffers 16-bit word writes from the CPU/host bus in a small FIFO and drains them into the VRAM write port, one word per pixel-clock enable. An optional clear engine sweeps a fill value across the framebuffer. It sits between the memory-mapped screen region of the CPU and the VRAM, opposite the VGA scan-out reader that consumes the same words.

## Interface

Parameters:
- FIFO_DEPTH, 4: host write buffer entries; power of two, ≥2.
- CLEAR_WORDS, 16384: number of words swept by a clear, at addresses 0..CLEAR_WORDS-1; range 1..16384.
- CLEAR_VALUE, 16'h0000: word written by the clear engine.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clken  in  1  write-slot enable, the same pixel-rate enable the VGA block uses; VRAM writes are issued only on edges where clken=1.
- wr_valid  in  1  host write request.
- wr_ready  out  1  write accepted on an edge where wr_valid && wr_ready.
- wr_addr  in  14  VRAM word address.
- wr_data  in  16  VRAM word data.
- clear_req  in  1  single-cycle clear request.
- busy  out  1  pending work: FIFO non-empty, clear pending or active, or vram_we high.
- vram_waddr  out  14  registered write address.
- vram_wdata  out  16  registered write data.
- vram_we  out  1  registered write strobe, one clk cycle per word.

## Operation

- FSM states are IDLE and CLEAR.
- **IDLE:** on an edge with clken=1 and the FIFO non-empty, pop the head entry and register vram_we=1, vram_waddr=entry.addr, vram_wdata=entry.data.
- **vram_we:** cleared on every edge that does not issue a write, so each write is a one-clk pulse.
- **clear_req in IDLE:** sets clear_pending.
  - Entries already in the FIFO drain first.
  - When the FIFO is empty and clear_pending=1, go to CLEAR, set the counter to 0 and clear clear_pending.
- **CLEAR:** on each edge with clken=1, write CLEAR_VALUE at the counter value, then increment the counter.
  - After writing CLEAR_WORDS-1, return to IDLE.
  - The counter is 14 bits and never wraps past CLEAR_WORDS-1.
- **clear_req while clear_pending or CLEAR:** ignored (no restart, no queueing).
- **wr_ready** = !full && !clear_pending && state==IDLE. It is combinational from registered state.
- **FIFO full:** no push/pop bypass, even if a pop occurs on the same edge.
- **Same-cycle wr_valid and clear_req:** if wr_ready=1, the write is accepted and is ordered before the clear.
- **clken=0:** no VRAM writes. The FIFO still accepts entries until full.

## Timing

- **Reset values:** vram_we=0, vram_waddr=0, vram_wdata=0, FIFO empty, state IDLE, clear_pending=0, counter 0. This gives wr_ready=1 and busy=0 in the cycle after reset.
- **Reset mid-operation:** reset in any state (including mid-CLEAR or with a non-empty FIFO) discards all work and returns to these values on the next edge.
- **Latency:** an entry accepted at edge E is written at the first edge after E with clken=1. vram_we is high in the following cycle.
  - Minimum latency is 1 edge to the strobe, with clken held high.
- **Throughput:** one word per clken edge.
- **Clear duration:** CLEAR_WORDS clken edges, measured from the FIFO going empty.

## Configuration

- **VRAM_WRITER_CLEAR_EN defined:** clear engine, CLEAR state, clear_pending and counter are present, as described above.
- **Undefined:**
  - clear_req is ignored.
  - The FSM is IDLE only.
  - wr_ready = !full.
  - busy = FIFO non-empty || vram_we.
  - CLEAR_WORDS and CLEAR_VALUE are unused.

## Structure

- Shared package vram_pkg:
  - VRAM_ADDR_W=14 and VRAM_DATA_W=16.
  - The writer state enum (IDLE, CLEAR).
  - The FIFO entry struct (addr, data).
- Sub-module sync_fifo holds the buffer: parameterised width and depth, push/pop/full/empty, synchronous active-high reset.
- vram_writer owns the FSM, the clear counter and the output registers.

## Test plan

- Reset, then write addr 0x0010 / data 0xABCD with clken toggling every other cycle → exactly one vram_we pulse, with addr 0x0010 and data 0xABCD, after the first clken edge following acceptance; busy then drops.
- clken=0, present 5 writes (addr 1..5, data 0x1111..0x5555) → the first 4 are accepted and wr_ready=0 on the 5th. Raise clken=1 → the 5th is accepted and all 5 are written in order, addresses 1..5.
- CLEAR_WORDS=16, clken=1, pulse clear_req → 16 consecutive pulses at addresses 0..15 with data 0x0000; wr_ready=0 throughout; busy falls after the last pulse.
- In one cycle, wr_valid (addr 0x3FFF, data 0xBEEF) and clear_req → 0x3FFF/0xBEEF is written first, then the clear sweep; a second clear_req mid-sweep has no effect.
- Reset asserted during a clear at counter 7 → vram_we=0 in the next cycle, busy=0, wr_ready=1; no further writes.
- Build without VRAM_WRITER_CLEAR_EN, pulse clear_req → no vram_we pulses, busy stays 0, wr_ready stays 1.
